pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter stage of the single-cycle MIPS core, directly upstream of instruction memory. Holds the 32-bit byte PC and drives the 10-bit word address into instruction memory. Computes the next PC from sequential, branch, jump and jump-register requests. Supports stall, syscall halt with board-button resume, and a retired-instruction counter for board display.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  system clock; all state updates on its rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- Stall  in  1  hold the PC this cycle.
- Branch  in  1  conditional branch taken; already resolved by the datapath.
- Imm16  in  16  branch offset in words; sign-extended.
- Jump  in  1  J/JAL request.
- JTarget  in  26  jump target field.
- JR  in  1  jump-register request.
- RegAddr  in  32  rs value for JR.
- Halt  in  1  current instruction is a syscall halt.
- Go  in  1  resume button, level input; synchronised internally.
- Step  in  1  single-step button; used only with PC_SINGLE_STEP_EN.
- StepMode  in  1  single-step enable switch; used only with PC_SINGLE_STEP_EN.
- PCNow  out  10  word address to instruction memory, equal to PC[11:2].
- PCOut  out  32  current byte PC.
- PCPlus4  out  32  PCOut + 4, for JAL link.
- Halted  out  1  high while in HALT state.
- InstCount  out  32  number of retired instructions.

## Operation
- PC register:
  - Reset value RESET_PC.
  - PCNow, PCOut and PCPlus4 are combinational from the PC register.
- Next-PC priority: JR > Jump > Branch > sequential.
  - JR: {RegAddr[31:2], 2'b00}. Low bits are forced to zero.
  - Jump: {PCPlus4[31:28], JTarget, 2'b00}.
  - Branch: PCPlus4 + {{14{Imm16[15]}}, Imm16, 2'b00}. Result is truncated to 32 bits.
  - Sequential: PCPlus4.
- All additions are modulo 2^32. PC 0xFFFF_FFFC wraps to 0x0000_0000.
- PCNow wraps every 4 KB because only PC[11:2] is driven.
- States: RUN, HALT, plus STEP_WAIT with the macro.
- RUN:
  - Stall=1: PC is held, no count, Halt ignored.
  - Stall=0 and Halt=1: PC is held on the syscall, go to HALT, InstCount is not incremented.
  - Otherwise: PC <= next PC and InstCount += 1.
- HALT:
  - PC is held and Halted=1.
  - A rising edge on the synchronised Go does PC <= PCPlus4, InstCount += 1, and returns to RUN.
  - Jump/Branch/JR are ignored while halted.
- Go edge detect uses a 2-flop synchroniser plus one delay flop. Go already high at reset does not count as an edge.
- InstCount wraps modulo 2^32. Its reset value is 0.
- Reset mid-operation, in any state and any cycle: PC=RESET_PC, state RUN, InstCount=0, Halted=0, synchroniser flops 0. Applies immediately, no clock needed.

## Timing
- PC update latency is one cycle. Inputs are sampled on the rising CLK that ends the instruction's cycle.
- Instruction memory output is valid in the same cycle as PCNow; this block adds no pipeline stage.
- Go resume latency: 3 CLK edges from the Go rising edge to PC advance (2 sync + 1 edge detect).
- Halted rises on the edge that samples Halt=1 and falls on the resume edge.
- Reset values: PCNow=RESET_PC[11:2], PCOut=RESET_PC, PCPlus4=RESET_PC+4, Halted=0, InstCount=0.

## Configuration
- PC_SINGLE_STEP_EN defined:
  - With StepMode=1, each retirement in RUN moves the state to STEP_WAIT.
  - STEP_WAIT holds the PC until a synchronised Step rising edge. Step uses the same 3-edge scheme as Go.
  - That edge returns the state to RUN for exactly one more retirement.
  - Halt in RUN still goes to HALT.
  - StepMode=0 behaves exactly as without the macro.
- PC_SINGLE_STEP_EN undefined: Step and StepMode are ignored, STEP_WAIT does not exist, and PC advances every unstalled cycle.

## Test plan
- Reset then 4 free cycles → PCOut 0,4,8,12,16; PCNow 0..4; InstCount=4. Assert RSTn low mid-cycle → PCOut=0 and InstCount=0 immediately.
- Branch at PC=0x10 with Imm16=16'hFFFC → next PC 0x04. Imm16=16'h0003 → next PC 0x20.
- Jump with JTarget=26'h0000040 at PC=0x8 → next PC 0x100. Jump and JR both high with RegAddr=0x203 → next PC 0x200.
- Stall=1 for 3 cycles at PC=0x24 → PC stays 0x24 and InstCount is unchanged. Stall=1 with Halt=1 → no halt.
- Halt=1 at PC=0x30 → Halted=1 and PC holds for 10 cycles. Pulse Go → 3 edges later PC=0x34, Halted=0, InstCount +1.
- With PC_SINGLE_STEP_EN and StepMode=1: PC advances 0→4 then holds. Each Step pulse advances by exactly one instruction.

Source files
------------

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: datapath <-> PC stage bundle.
// master = datapath / board side, slave = pc_fetch_unit.
interface pc_fetch_unit_if;
    logic        Stall;
    logic        Branch;
    logic [15:0] Imm16;
    logic        Jump;
    logic [25:0] JTarget;
    logic        JR;
    logic [31:0] RegAddr;
    logic        Halt;
    logic        Go;
    logic        Step;
    logic        StepMode;
    logic [9:0]  PCNow;
    logic [31:0] PCOut;
    logic [31:0] PCPlus4;
    logic        Halted;
    logic [31:0] InstCount;

    modport master (
        output Stall, Branch, Imm16, Jump, JTarget, JR, RegAddr,
        output Halt, Go, Step, StepMode,
        input  PCNow, PCOut, PCPlus4, Halted, InstCount
    );

    modport slave (
        input  Stall, Branch, Imm16, Jump, JTarget, JR, RegAddr,
        input  Halt, Go, Step, StepMode,
        output PCNow, PCOut, PCPlus4, Halted, InstCount
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register, next-PC select, syscall halt and retire count.
// Define PC_SINGLE_STEP_EN to add the STEP_WAIT single-step state.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           CLK,
    input  logic           RSTn,
    pc_fetch_unit_if.slave bus
);

`ifdef PC_SINGLE_STEP_EN
    typedef enum logic [1:0] {RUN, HALT, STEP_WAIT} state_t;
`else
    typedef enum logic [0:0] {RUN, HALT} state_t;
`endif

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] br_off;
    logic [31:0] npc;
    logic [31:0] cnt;
    logic        halted;
    logic        prm1, prm2;
    logic        go_s1, go_s2, go_d, go_arm;
    logic        go_rise;

    assign pc_plus4 = pc + 32'd4;
    assign br_off   = {{14{bus.Imm16[15]}}, bus.Imm16, 2'b00};

    always_comb begin
        npc = pc_plus4;
        priority case (1'b1)
            bus.JR:     npc = {bus.RegAddr[31:2], 2'b00};
            bus.Jump:   npc = {pc_plus4[31:28], bus.JTarget, 2'b00};
            bus.Branch: npc = pc_plus4 + br_off;
            default:    npc = pc_plus4;
        endcase
    end

    // A button already high when reset releases must drop before a rise counts.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            prm1   <= 1'b0;
            prm2   <= 1'b0;
            go_s1  <= 1'b0;
            go_s2  <= 1'b0;
            go_d   <= 1'b0;
            go_arm <= 1'b0;
        end else begin
            prm1   <= 1'b1;
            prm2   <= prm1;
            go_s1  <= bus.Go;
            go_s2  <= go_s1;
            go_d   <= go_s2;
            go_arm <= go_arm | (prm2 & ~go_s2);
        end
    end

    assign go_rise = go_s2 & ~go_d & go_arm;

`ifdef PC_SINGLE_STEP_EN
    logic st_s1, st_s2, st_d, st_arm;
    logic step_rise;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            st_s1  <= 1'b0;
            st_s2  <= 1'b0;
            st_d   <= 1'b0;
            st_arm <= 1'b0;
        end else begin
            st_s1  <= bus.Step;
            st_s2  <= st_s1;
            st_d   <= st_s2;
            st_arm <= st_arm | (prm2 & ~st_s2);
        end
    end

    assign step_rise = st_s2 & ~st_d & st_arm;
`else
    logic unused_in;
    assign unused_in = ^{bus.Step, bus.StepMode, bus.RegAddr[1:0]};
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state  <= RUN;
            pc     <= RESET_PC;
            cnt    <= 32'd0;
            halted <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (!bus.Stall) begin
                        if (bus.Halt) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            pc  <= npc;
                            cnt <= cnt + 32'd1;
`ifdef PC_SINGLE_STEP_EN
                            if (bus.StepMode) state <= STEP_WAIT;
`endif
                        end
                    end
                end
                HALT: begin
                    if (go_rise) begin
                        pc     <= pc_plus4;
                        cnt    <= cnt + 32'd1;
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
`ifdef PC_SINGLE_STEP_EN
                STEP_WAIT: begin
                    if (step_rise || !bus.StepMode) state <= RUN;
                end
`endif
                default: state <= RUN;
            endcase
        end
    end

    assign bus.PCNow     = pc[11:2];
    assign bus.PCOut     = pc;
    assign bus.PCPlus4   = pc_plus4;
    assign bus.Halted    = halted;
    assign bus.InstCount = cnt;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed plus random stimulus against a reference model.
// Default build only (PC_SINGLE_STEP_EN undefined).
module tb_pc_fetch_unit;

    logic clk;
    logic rstn;

    pc_fetch_unit_if bus ();

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .CLK  (clk),
        .RSTn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    bit          m_halt;
    bit          gq[$];

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_next(logic [31:0] p);
        logic [31:0] p4;
        p4 = p + 32'd4;
        if (bus.JR) return bus.RegAddr & 32'hFFFF_FFFC;
        if (bus.Jump)
            return (p4 & 32'hF000_0000) | ({6'd0, bus.JTarget} << 2);
        if (bus.Branch) return p4 + 32'(int'($signed(bus.Imm16)) * 4);
        return p4;
    endfunction

    task automatic model_reset();
        m_pc   = 32'h0000_0000;
        m_cnt  = 32'd0;
        m_halt = 1'b0;
        gq.delete();
    endtask

    task automatic compare();
        chk("pcout", bus.PCOut, m_pc);
        chk("pcnow", {22'd0, bus.PCNow}, {22'd0, m_pc[11:2]});
        chk("pcplus4", bus.PCPlus4, m_pc + 32'd4);
        chk("halted", {31'd0, bus.Halted}, {31'd0, m_halt});
        chk("count", bus.InstCount, m_cnt);
    endtask

    // Resume fires on edge n when Go was sampled high at edge n-2 and low at n-3.
    task automatic tick();
        int  n;
        bit  rise;
        @(posedge clk);
        gq.push_back(bus.Go);
        n = gq.size();
        rise = (n >= 4) && gq[n-3] && !gq[n-4];
        if (!m_halt) begin
            if (!bus.Stall) begin
                if (bus.Halt) m_halt = 1'b1;
                else begin
                    m_pc  = ref_next(m_pc);
                    m_cnt = m_cnt + 32'd1;
                end
            end
        end else if (rise) begin
            m_pc   = m_pc + 32'd4;
            m_cnt  = m_cnt + 32'd1;
            m_halt = 1'b0;
        end
        #1;
        compare();
    endtask

    task automatic do_reset();
        #2 rstn = 1'b0;
        #1;
        model_reset();
        compare();
        chk("rst_pc", bus.PCOut, 32'h0);
        chk("rst_cnt", bus.InstCount, 32'h0);
        #2 rstn = 1'b1;
    endtask

    task automatic idle_inputs();
        bus.Stall    = 1'b0;
        bus.Branch   = 1'b0;
        bus.Imm16    = 16'h0;
        bus.Jump     = 1'b0;
        bus.JTarget  = 26'h0;
        bus.JR       = 1'b0;
        bus.RegAddr  = 32'h0;
        bus.Halt     = 1'b0;
        bus.Step     = 1'b0;
        bus.StepMode = 1'b0;
    endtask

    initial begin
        rstn   = 1'b0;
        bus.Go = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        compare();
        chk("rst_pcplus4", bus.PCPlus4, 32'h4);
        rstn = 1'b1;

        repeat (4) tick();
        chk("free4_pc", bus.PCOut, 32'h10);
        chk("free4_cnt", bus.InstCount, 32'd4);

        bus.Branch = 1'b1;
        bus.Imm16  = 16'hFFFC;
        tick();
        chk("br_back", bus.PCOut, 32'h4);
        bus.Branch = 1'b0;
        repeat (3) tick();
        bus.Branch = 1'b1;
        bus.Imm16  = 16'h0003;
        tick();
        chk("br_fwd", bus.PCOut, 32'h20);
        bus.Branch = 1'b0;

        do_reset();
        repeat (2) tick();
        bus.Jump    = 1'b1;
        bus.JTarget = 26'h0000040;
        tick();
        chk("jump", bus.PCOut, 32'h100);
        bus.JR      = 1'b1;
        bus.RegAddr = 32'h203;
        tick();
        chk("jr_prio", bus.PCOut, 32'h200);
        idle_inputs();

        bus.Stall = 1'b1;
        repeat (3) tick();
        chk("stall_pc", bus.PCOut, 32'h200);
        bus.Halt = 1'b1;
        tick();
        chk("stall_nohalt", {31'd0, bus.Halted}, 32'd0);
        bus.Stall = 1'b0;
        tick();
        chk("halt_on", {31'd0, bus.Halted}, 32'd1);
        bus.Halt   = 1'b0;
        bus.Branch = 1'b1;
        repeat (10) tick();
        chk("halt_hold", bus.PCOut, 32'h200);
        bus.Branch = 1'b0;
        bus.Go     = 1'b1;
        repeat (2) tick();
        chk("go_wait", {31'd0, bus.Halted}, 32'd1);
        tick();
        chk("go_pc", bus.PCOut, 32'h204);
        chk("go_halted", {31'd0, bus.Halted}, 32'd0);
        bus.Go = 1'b0;

        bus.JR      = 1'b1;
        bus.RegAddr = 32'hFFFF_FFFF;
        tick();
        chk("jr_top", bus.PCOut, 32'hFFFF_FFFC);
        bus.JR = 1'b0;
        tick();
        chk("wrap", bus.PCOut, 32'h0);

        bus.Go = 1'b1;
        do_reset();
        bus.Halt = 1'b1;
        tick();
        bus.Halt = 1'b0;
        repeat (6) tick();
        chk("go_high_rst", {31'd0, bus.Halted}, 32'd1);
        bus.Go = 1'b0;
        repeat (3) tick();
        bus.Go = 1'b1;
        repeat (3) tick();
        chk("go_after_low", {31'd0, bus.Halted}, 32'd0);
        bus.Go = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            bus.Stall    = ($urandom_range(0, 4) == 0);
            bus.Branch   = ($urandom_range(0, 2) == 0);
            bus.Imm16    = 16'($urandom);
            bus.Jump     = ($urandom_range(0, 5) == 0);
            bus.JTarget  = 26'($urandom);
            bus.JR       = ($urandom_range(0, 7) == 0);
            bus.RegAddr  = $urandom;
            bus.Halt     = ($urandom_range(0, 19) == 0);
            bus.Step     = 1'($urandom);
            bus.StepMode = 1'($urandom);
            if ($urandom_range(0, 5) == 0) bus.Go = ~bus.Go;
            if ($urandom_range(0, 299) == 0) do_reset();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
        $finish;
    end

endmodule
